// File: rtl/approx_eval_pkg.sv
// Shared types and widths for the approximate-multiplier error evaluator.
package approx_eval_pkg;

  localparam int SAMPLE_W_DEF = 17;
  localparam int SUM_W_DEF    = 33;
  localparam int ED_W         = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/approx_mul_err_eval_ed_calc.sv
// Absolute error distance between the exact and the approximate 16-bit product.
module ed_calc
  import approx_eval_pkg::*;
(
  input  logic [ED_W-1:0] exact,
  input  logic [ED_W-1:0] prod,
  output logic [ED_W-1:0] ed
);

  always_comb begin
    if (exact >= prod) ed = exact - prod;
    else               ed = prod - exact;
  end

endmodule

// File: rtl/approx_mul_err_eval.sv
// Error-statistics stage for 8x8 approximate multipliers: three-stage pipeline
// (exact product, error distance, accumulate) under a run/drain controller.
module approx_mul_err_eval
  import approx_eval_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int SUM_W    = SUM_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SAMPLE_W-1:0] num_samples,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_a,
  input  logic [7:0]          in_b,
  input  logic [15:0]         in_prod,
  output logic                busy,
  output logic                done,
  output logic [SAMPLE_W-1:0] err_count,
  output logic [SUM_W-1:0]    sum_ed,
  output logic [ED_W-1:0]     max_ed,
  output logic [7:0]          max_a,
  output logic [7:0]          max_b
);

  state_t              state_reg, state_next;
  logic [SAMPLE_W-1:0] nsamp_reg, cnt_reg, cnt_inc;
  logic                accept, start_ok, done_next, done_reg;
  logic [2:0]          vld_reg;

  logic [7:0]          s1_a_reg, s1_b_reg, s2_a_reg, s2_b_reg, s3_a_reg, s3_b_reg;
  logic [ED_W-1:0]     s1_prod_reg, s1_exact_reg, ed_next, s2_ed_reg, s3_ed_reg;

  logic [SAMPLE_W-1:0] err_reg;
  logic [SUM_W-1:0]    sum_reg;
  logic [ED_W-1:0]     max_reg;
  logic [7:0]          max_a_reg, max_b_reg;

  assign accept   = in_valid && (state_reg == RUN);
  assign start_ok = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign cnt_inc  = cnt_reg + SAMPLE_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    unique case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          if (num_samples == '0) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (accept && (cnt_inc == nsamp_reg)) state_next = DRAIN;
      end
      DRAIN: begin
        // Only the accumulate stage may still hold data; it retires on this same edge.
        if (!vld_reg[0] && !vld_reg[1]) begin
          state_next = DONE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_reg  <= 1'b0;
      cnt_reg   <= '0;
      nsamp_reg <= '0;
    end else begin
      done_reg <= done_next;
      if (start_ok) begin
        cnt_reg   <= '0;
        nsamp_reg <= num_samples;
      end else if (accept) begin
        cnt_reg <= cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_reg <= '0;
    else     vld_reg <= {vld_reg[1:0], accept};
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a_reg     <= in_a;
      s1_b_reg     <= in_b;
      s1_prod_reg  <= in_prod;
      s1_exact_reg <= 16'(in_a) * 16'(in_b);
    end
    s2_a_reg  <= s1_a_reg;
    s2_b_reg  <= s1_b_reg;
    s2_ed_reg <= ed_next;
    s3_a_reg  <= s2_a_reg;
    s3_b_reg  <= s2_b_reg;
    s3_ed_reg <= s2_ed_reg;
  end

  ed_calc u_ed_calc (
    .exact (s1_exact_reg),
    .prod  (s1_prod_reg),
    .ed    (ed_next)
  );

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      err_reg   <= '0;
      sum_reg   <= '0;
      max_reg   <= '0;
      max_a_reg <= '0;
      max_b_reg <= '0;
    end else if (vld_reg[2]) begin
      sum_reg <= sum_reg + SUM_W'(s3_ed_reg);
      if (s3_ed_reg != '0) err_reg <= err_reg + SAMPLE_W'(1);
      // Strict compare keeps the operands of the first sample that hit the maximum.
      if (s3_ed_reg > max_reg) begin
        max_reg   <= s3_ed_reg;
        max_a_reg <= s3_a_reg;
        max_b_reg <= s3_b_reg;
      end
    end
  end

  assign in_ready  = (state_reg == RUN);
  assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
  assign done      = done_reg;
  assign err_count = err_reg;
  assign sum_ed    = sum_reg;
  assign max_ed    = max_reg;
  assign max_a     = max_a_reg;
  assign max_b     = max_b_reg;

endmodule

// File: tb/tb_approx_mul_err_eval.sv
// Directed-vector bench with a timestamp-based reference model checked every cycle.
module tb_approx_mul_err_eval;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [16:0] num_samples;
  logic [7:0]  in_a, in_b;
  logic [15:0] in_prod;
  logic        in_ready, busy, done;
  logic [16:0] err_count;
  logic [32:0] sum_ed;
  logic [15:0] max_ed;
  logic [7:0]  max_a, max_b;

  approx_mul_err_eval #(.SAMPLE_W(17), .SUM_W(33)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_prod(in_prod), .busy(busy), .done(done), .err_count(err_count),
    .sum_ed(sum_ed), .max_ed(max_ed), .max_a(max_a), .max_b(max_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: each accepted sample is due in the results 3 edges later.
  typedef struct {
    int     a;
    int     b;
    int     p;
    longint due;
  } samp_t;

  samp_t  q[$];
  samp_t  s;
  longint e = 0;
  longint done_due = -1;
  bit     m_ready = 0, m_busy = 0, m_done = 0, was_busy, was_ready;
  longint m_n = 0, m_acc = 0, m_err = 0, m_sum = 0;
  int     m_max = 0, m_ma = 0, m_mb = 0, x;

  always @(posedge clk) begin
    e++;
    if (rst) begin
      q.delete();
      m_ready = 0; m_busy = 0; m_done = 0; done_due = -1;
      m_acc = 0; m_err = 0; m_sum = 0; m_max = 0; m_ma = 0; m_mb = 0;
    end else begin
      was_busy  = m_busy;
      was_ready = m_ready;
      while (q.size() > 0 && q[0].due == e) begin
        s = q.pop_front();
        x = s.a * s.b - s.p;
        if (x < 0) x = -x;
        m_sum += x;
        if (x != 0) m_err++;
        if (x > m_max) begin
          m_max = x; m_ma = s.a; m_mb = s.b;
        end
      end
      m_done = 0;
      if (m_busy && !m_ready && done_due == e) begin
        m_busy = 0;
        m_done = 1;
      end
      if (was_ready && in_valid) begin
        s.a = int'(in_a); s.b = int'(in_b); s.p = int'(in_prod); s.due = e + 3;
        q.push_back(s);
        m_acc++;
        if (m_acc == m_n) begin
          m_ready  = 0;
          done_due = e + 3;
        end
      end
      if (!was_busy && start) begin
        m_n = longint'(num_samples);
        m_acc = 0; m_err = 0; m_sum = 0; m_max = 0; m_ma = 0; m_mb = 0;
        if (m_n == 0) m_done = 1;
        else begin
          m_ready = 1;
          m_busy  = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (e > 0) begin
      chk("in_ready", in_ready, m_ready);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("err_count", err_count, m_err);
      chk("sum_ed", sum_ed, m_sum);
      chk("max_ed", max_ed, m_max);
      chk("max_a", max_a, m_ma);
      chk("max_b", max_b, m_mb);
    end
  end

  logic [7:0]  va [8];
  logic [7:0]  vb [8];
  logic [15:0] vp [8];

  task automatic set_vec(input int i, input int a, input int b, input int p);
    va[i] = 8'(a);
    vb[i] = 8'(b);
    vp[i] = 16'(p);
  endtask

  task automatic run(input string name, input int n, input bit exh, input bit gappy,
                     input bit mid_start);
    int idx, cyc, w;
    bit acc;
    @(negedge clk);
    start = 1'b1; num_samples = 17'(n); in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    idx = 0; cyc = 0;
    while (idx < n && cyc < 2 * n + 20) begin
      in_valid = gappy ? (cyc % 2 == 0) : 1'b1;
      if (exh) begin
        in_a = 8'(idx >> 8); in_b = 8'(idx); in_prod = 16'(in_a) * 16'(in_b);
      end else begin
        in_a = va[idx]; in_b = vb[idx]; in_prod = vp[idx];
      end
      start = mid_start && (cyc == 3);
      if (start) num_samples = 17'd2;
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk({name, " accepts"}, idx, n);
    w = 1;
    while (!done && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({name, " done_lat"}, w, 4);
    $display("run %s: samples=%0d err_count=%0d sum_ed=%0d max_ed=%0d max_a=%0d max_b=%0d",
             name, idx, err_count, sum_ed, max_ed, max_a, max_b);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_samples = '0;
    in_a = '0; in_b = '0; in_prod = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", busy, 0);
    chk("reset sum_ed", sum_ed, 0);
    chk("reset in_ready", in_ready, 0);

    run("exhaustive", 65536, 1'b1, 1'b0, 1'b0);
    chk("exh err_count", err_count, 0);
    chk("exh sum_ed", sum_ed, 0);
    chk("exh max_ed", max_ed, 0);

    set_vec(0, 255, 255, 0);
    run("single", 1, 1'b0, 1'b0, 1'b0);
    chk("single sum_ed", sum_ed, 65025);
    chk("single max_ed", max_ed, 65025);
    chk("single max_a", max_a, 255);
    chk("single max_b", max_b, 255);
    chk("single err_count", err_count, 1);

    set_vec(0, 2, 3, 11); set_vec(1, 4, 4, 7); set_vec(2, 7, 7, 58);
    run("tie", 3, 1'b0, 1'b0, 1'b0);
    chk("tie max_ed", max_ed, 9);
    chk("tie max_a", max_a, 4);
    chk("tie max_b", max_b, 4);
    chk("tie sum_ed", sum_ed, 23);
    chk("tie err_count", err_count, 3);

    @(negedge clk);
    start = 1'b1; num_samples = '0;
    @(negedge clk);
    start = 1'b0;
    chk("zero done", done, 1);
    chk("zero sum_ed", sum_ed, 0);
    chk("zero max_ed", max_ed, 0);
    chk("zero in_ready", in_ready, 0);
    @(negedge clk);
    chk("zero done_pulse", done, 0);
    $display("run zero: samples=0 err_count=%0d sum_ed=%0d", err_count, sum_ed);

    set_vec(0, 10, 10, 100); set_vec(1, 3, 5, 20); set_vec(2, 200, 2, 390); set_vec(3, 1, 1, 1);
    run("gappy", 4, 1'b0, 1'b1, 1'b1);
    chk("gappy err_count", err_count, 2);
    chk("gappy sum_ed", sum_ed, 15);
    chk("gappy max_ed", max_ed, 10);
    chk("gappy max_a", max_a, 200);
    chk("gappy max_b", max_b, 2);

    @(negedge clk);
    start = 1'b1; num_samples = 17'd10;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_a = 8'd255; in_b = 8'd255; in_prod = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort in_ready", in_ready, 0);
    chk("abort done", done, 0);
    chk("abort sum_ed", sum_ed, 0);
    repeat (3) @(negedge clk);
    chk("abort late sum_ed", sum_ed, 0);
    chk("abort late err_count", err_count, 0);
    $display("run abort: err_count=%0d sum_ed=%0d", err_count, sum_ed);

    set_vec(0, 2, 3, 11); set_vec(1, 4, 4, 7); set_vec(2, 7, 7, 58);
    run("fresh", 3, 1'b0, 1'b0, 1'b0);
    chk("fresh sum_ed", sum_ed, 23);
    chk("fresh max_ed", max_ed, 9);
    chk("fresh err_count", err_count, 3);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
